// File: rtl/jk_drv_pkg.sv
// Shared types and the JK excitation function for the state-to-JK drive block.
package jk_drv_pkg;

   typedef enum logic [0:0] {
      StInit,
      StRun
   } drv_state_e;

   typedef struct packed {
      logic j;
      logic k;
   } jk_t;

   typedef struct packed {
      logic valid;
      logic exp;
   } chk_t;

   // dc_mode=0 fills don't-cares with 0 (hold/set/reset); dc_mode=1 prefers toggle.
   function automatic jk_t jk_excite(input logic q, input logic t, input logic dc_mode);
      jk_t r;
      if (dc_mode) begin
         r.j = q | t;
         r.k = ~(q & t);
      end else begin
         r.j = ~q & t;
         r.k = q & ~t;
      end
      return r;
   endfunction

endpackage

// File: rtl/bit_fifo.sv
// Single-bit FIFO; pointers carry one extra wrap bit to tell full from empty.
module bit_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  logic data_i,
   input  logic pop_i,
   output logic data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]      wptr_q, rptr_q;
   logic [DEPTH-1:0] mem_q;
   logic             do_push, do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign data_o  = mem_q[rptr_q[AW-1:0]];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + (AW + 1)'(1);
         if (do_pop)  rptr_q <= rptr_q + (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/jk_excite_driver.sv
// Turns a stream of desired flop states into registered J/K drive and checks the
// flop's slave output a fixed number of edges later.
module jk_excite_driver
   import jk_drv_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned FB_LAT  = 2,
   parameter int unsigned DC_MODE = 0,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   input  logic             tgt_bit,
   output logic             tgt_ready,
   output logic             j,
   output logic             k,
   input  logic             qs,
   input  logic             err_clr,
   output logic             q_exp,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic DC_BIT = (DC_MODE != 0);

   drv_state_e       state_q, state_d;
   jk_t              jk_q, jk_d;
   logic             q_exp_q, q_exp_d;
   chk_t             chk_q [FB_LAT];
   chk_t             chk_in;
   logic             err_q, err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic fifo_full, fifo_empty, fifo_data;
   logic push, pop;
   logic mismatch, chk_pend;

   assign tgt_ready = (state_q == StRun) && !fifo_full;
   assign push      = tgt_valid && tgt_ready;
   assign pop       = (state_q == StRun) && !fifo_empty;

   bit_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (push),
      .data_i  (tgt_bit),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      jk_d    = '0;
      q_exp_d = q_exp_q;
      chk_in  = '0;
      unique case (state_q)
         StInit: begin
            // Force a known 0 in the flop before any target is applied.
            jk_d    = '{j: 1'b0, k: 1'b1};
            q_exp_d = 1'b0;
            chk_in  = '{valid: 1'b1, exp: 1'b0};
            state_d = StRun;
         end
         StRun: begin
            if (pop) begin
               jk_d    = jk_excite(q_exp_q, fifo_data, DC_BIT);
               q_exp_d = fifo_data;
               chk_in  = '{valid: 1'b1, exp: fifo_data};
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_comb begin
      chk_pend = 1'b0;
      for (int i = 0; i < int'(FB_LAT); i++) begin
         chk_pend = chk_pend | chk_q[i].valid;
      end
   end

   assign mismatch = chk_q[FB_LAT-1].valid && (qs != chk_q[FB_LAT-1].exp);

   always_comb begin
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      if (err_clr) begin
         // A mismatch on the clearing edge survives as the first new error.
         err_d     = mismatch;
         err_cnt_d = mismatch ? CNT_W'(1) : '0;
      end else if (mismatch) begin
         err_d = 1'b1;
         if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StInit;
         jk_q      <= '0;
         q_exp_q   <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         for (int i = 0; i < int'(FB_LAT); i++) chk_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         jk_q      <= jk_d;
         q_exp_q   <= q_exp_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         chk_q[0]  <= chk_in;
         for (int i = 1; i < int'(FB_LAT); i++) chk_q[i] <= chk_q[i-1];
      end
   end

   assign j       = jk_q.j;
   assign k       = jk_q.k;
   assign q_exp   = q_exp_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;
   // The INIT step counts as pending work only once reset has been released.
   assign busy    = !fifo_empty || chk_pend || ((state_q == StInit) && rst);

endmodule
